step_ramp_gen: RTL and testbench

Trapezoidal step-pulse generator for one stepper axis. It accepts a move command: pulse count, start period, minimum period and period step. It emits a step pulse train that accelerates, cruises and decelerates symmetrically, plus a direction level. Pls_Out and Dir drive the axis control stage directly, in place of its fixed-rate pulse source; that stage counts the pulses for position. One instance per axis.

---
 rtl/step_ramp_gen_if.sv | 31 +++
 rtl/step_ramp_gen.sv | 143 ++++++++++++++
 tb/tb_step_ramp_gen.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/step_ramp_gen_if.sv
// rtl/step_ramp_gen_if.sv - Move command and pulse/status bundle for one stepper axis.
interface step_ramp_gen_if #(
    parameter int DIV_W = 16,
    parameter int CNT_W = 16
);
    logic             Start;
    logic             Stop;
    logic             Abort;
    logic             DirIn;
    logic [CNT_W-1:0] TotalPls;
    logic [DIV_W-1:0] StartDiv;
    logic [DIV_W-1:0] MinDiv;
    logic [DIV_W-1:0] AccStep;
    logic             Pls_Out;
    logic             Dir;
    logic             Busy;
    logic             Done;
    logic             Err;
    logic [CNT_W-1:0] PlsLeft;
    logic [DIV_W-1:0] CurDiv;

    modport master (
        output Start, Stop, Abort, DirIn, TotalPls, StartDiv, MinDiv, AccStep,
        input  Pls_Out, Dir, Busy, Done, Err, PlsLeft, CurDiv
    );

    modport slave (
        input  Start, Stop, Abort, DirIn, TotalPls, StartDiv, MinDiv, AccStep,
        output Pls_Out, Dir, Busy, Done, Err, PlsLeft, CurDiv
    );
endinterface

// File: rtl/step_ramp_gen.sv
// rtl/step_ramp_gen.sv - Trapezoidal step-pulse generator: accelerate, cruise, decelerate per move.
module step_ramp_gen #(
    parameter int DIV_W  = 16,
    parameter int CNT_W  = 16,
    parameter int PLS_HI = 8
) (
    input logic            Clk,
    input logic            ngRst,
    step_ramp_gen_if.slave bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCEL  = 2'd1;
    localparam logic [1:0] S_CRUISE = 2'd2;
    localparam logic [1:0] S_DECEL  = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] ramp_cnt;
    logic [CNT_W-1:0] pls_left;
    logic [DIV_W-1:0] cur_div;
    logic [DIV_W-1:0] per_cnt;
    logic [DIV_W-1:0] start_div;
    logic [DIV_W-1:0] min_div;
    logic [DIV_W-1:0] acc_step;
    logic             stop_req;
    logic             first_pls;
    logic             zero_pend;
    logic             pls;
    logic             dir;
    logic             busy;
    logic             done;
    logic             err;

    logic [DIV_W:0]   dec_w;
    logic [DIV_W:0]   inc_w;
    logic [DIV_W-1:0] dec_div;
    logic [DIV_W-1:0] inc_div;
    logic             params_ok;
    logic             finish;

    // One extra bit keeps the borrow/carry so the period saturates instead of wrapping.
    assign dec_w   = {1'b0, cur_div} - {1'b0, acc_step};
    assign inc_w   = {1'b0, cur_div} + {1'b0, acc_step};
    assign dec_div = (dec_w[DIV_W] || (dec_w[DIV_W-1:0] < min_div)) ? min_div : dec_w[DIV_W-1:0];
    assign inc_div = (inc_w > {1'b0, start_div}) ? start_div : inc_w[DIV_W-1:0];

    assign params_ok = ({1'b0, bus.MinDiv} >= (DIV_W+1)'(2 * PLS_HI)) && (bus.StartDiv >= bus.MinDiv);
    assign finish    = (pls_left == '0) || (stop_req && (state == S_DECEL) && (ramp_cnt == '0));

    always_ff @(posedge Clk or negedge ngRst) begin
        if (!ngRst) begin
            state     <= S_IDLE;
            ramp_cnt  <= '0;
            pls_left  <= '0;
            cur_div   <= '0;
            per_cnt   <= '0;
            start_div <= '0;
            min_div   <= '0;
            acc_step  <= '0;
            stop_req  <= 1'b0;
            first_pls <= 1'b0;
            zero_pend <= 1'b0;
            pls       <= 1'b0;
            dir       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == S_IDLE) begin
                if (zero_pend) begin
                    // A zero-length move reports Done one edge after it was accepted.
                    zero_pend <= 1'b0;
                    done      <= !bus.Abort;
                end else if (bus.Start) begin
                    if (!params_ok) begin
                        err <= 1'b1;
                    end else begin
                        err       <= 1'b0;
                        dir       <= bus.DirIn;
                        pls_left  <= bus.TotalPls;
                        cur_div   <= bus.StartDiv;
                        start_div <= bus.StartDiv;
                        min_div   <= bus.MinDiv;
                        acc_step  <= bus.AccStep;
                        ramp_cnt  <= '0;
                        stop_req  <= 1'b0;
                        if (bus.TotalPls == '0) begin
                            zero_pend <= 1'b1;
                        end else begin
                            state     <= S_ACCEL;
                            busy      <= 1'b1;
                            first_pls <= 1'b1;
                            per_cnt   <= bus.StartDiv;
                        end
                    end
                end
            end else if (bus.Abort) begin
                state     <= S_IDLE;
                busy      <= 1'b0;
                pls       <= 1'b0;
                stop_req  <= 1'b0;
                first_pls <= 1'b0;
            end else begin
                if (bus.Stop) stop_req <= 1'b1;
                if (per_cnt == cur_div) begin
                    if (!first_pls && finish) begin
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        stop_req <= 1'b0;
                    end else begin
                        if (first_pls) begin
                            first_pls <= 1'b0;
                        end else if ((pls_left <= ramp_cnt) || stop_req) begin
                            state   <= S_DECEL;
                            cur_div <= inc_div;
                            if (ramp_cnt != '0) ramp_cnt <= ramp_cnt - 1'b1;
                        end else if ((state == S_ACCEL) && (cur_div > min_div)) begin
                            cur_div  <= dec_div;
                            ramp_cnt <= ramp_cnt + 1'b1;
                        end else begin
                            state <= S_CRUISE;
                        end
                        pls      <= 1'b1;
                        pls_left <= pls_left - 1'b1;
                        per_cnt  <= DIV_W'(1);
                    end
                end else begin
                    per_cnt <= per_cnt + 1'b1;
                    if (per_cnt == DIV_W'(PLS_HI)) pls <= 1'b0;
                end
            end
        end
    end

    assign bus.Pls_Out = pls;
    assign bus.Dir     = dir;
    assign bus.Busy    = busy;
    assign bus.Done    = done;
    assign bus.Err     = err;
    assign bus.PlsLeft = pls_left;
    assign bus.CurDiv  = cur_div;
endmodule

// File: tb/tb_step_ramp_gen.sv
// tb/tb_step_ramp_gen.sv - Self-checking bench for step_ramp_gen against a pulse-list reference model.
module tb_step_ramp_gen;
    localparam int DIV_W  = 16;
    localparam int CNT_W  = 16;
    localparam int PLS_HI = 8;

    logic clk = 1'b0;
    logic ng_rst = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_per[$];
    int   exp_left;

    step_ramp_gen_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) bus ();

    step_ramp_gen #(.DIV_W(DIV_W), .CNT_W(CNT_W), .PLS_HI(PLS_HI)) dut (
        .Clk   (clk),
        .ngRst (ng_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse-by-pulse list of periods the move should produce; stop_at is the pulse during which Stop arrives.
    task automatic model(input int total, input int sd, input int md, input int acc, input int stop_at);
        int div, left, ramps, phase;
        bit stopping;
        exp_per.delete();
        div = sd; left = total; ramps = 0; phase = 0; stopping = 0;
        while (1) begin
            exp_per.push_back(div);
            left--;
            if (exp_per.size() == stop_at) stopping = 1;
            if (left == 0 || (stopping && phase == 2 && ramps == 0)) break;
            if (left <= ramps || stopping) begin
                phase = 2;
                div = (div + acc > sd) ? sd : div + acc;
                if (ramps > 0) ramps--;
            end else if (phase == 0 && div > md) begin
                div = (div - acc < md) ? md : div - acc;
                ramps++;
            end else begin
                phase = 1;
            end
        end
        exp_left = left;
    endtask

    task automatic issue_start(input int total, input int sd, input int md, input int acc, input bit dir);
        @(negedge clk);
        bus.TotalPls = CNT_W'(total);
        bus.StartDiv = DIV_W'(sd);
        bus.MinDiv   = DIV_W'(md);
        bus.AccStep  = DIV_W'(acc);
        bus.DirIn    = dir;
        bus.Start    = 1'b1;
        @(negedge clk);
        bus.Start    = 1'b0;
    endtask

    task automatic do_move(input int total, input int sd, input int md, input int acc, input bit dir,
                           input int stop_at, input int restart_at);
        int rises[$];
        int highs[$];
        int divs[$];
        int n_start, done_at, budget, since_rise, left_at_done, sum, bad_hi, per;
        bit prev, got_done, busy_at_done;
        model(total, sd, md, acc, stop_at);
        sum = 0;
        foreach (exp_per[i]) sum += exp_per[i];
        budget = sum + 100;
        issue_start(total, sd, md, acc, dir);
        n_start = cyc;
        check("start_busy", bus.Busy, 1);
        check("start_err", bus.Err, 0);
        check("start_dir", bus.Dir, dir);
        prev = 0; got_done = 0; since_rise = 0; done_at = -1; left_at_done = -1; busy_at_done = 1;
        for (int t = 0; t < budget && !got_done; t++) begin
            @(negedge clk);
            bus.Stop = 1'b0;
            bus.Start = 1'b0;
            if (bus.Pls_Out && !prev) begin
                rises.push_back(cyc - n_start);
                highs.push_back(0);
                divs.push_back(int'(bus.CurDiv));
                since_rise = 0;
            end
            if (bus.Pls_Out) highs[highs.size()-1] += 1;
            prev = bus.Pls_Out;
            since_rise++;
            if (stop_at != 0 && rises.size() == stop_at && since_rise == 3) bus.Stop = 1'b1;
            if (restart_at != 0 && rises.size() == restart_at && since_rise == 3) begin
                bus.TotalPls = CNT_W'(2);
                bus.StartDiv = DIV_W'(200);
                bus.MinDiv   = DIV_W'(30);
                bus.DirIn    = ~dir;
                bus.Start    = 1'b1;
            end
            if (bus.Done) begin
                got_done = 1;
                done_at = cyc - n_start;
                left_at_done = int'(bus.PlsLeft);
                busy_at_done = bus.Busy;
            end
        end
        check("move_done", got_done, 1);
        check("pulse_count", rises.size(), exp_per.size());
        if (rises.size() > 0) check("first_rise", rises[0], 1);
        bad_hi = 0;
        for (int i = 0; i < rises.size() && i < exp_per.size(); i++) begin
            per = (i + 1 < rises.size()) ? rises[i+1] - rises[i] : done_at - rises[i];
            check($sformatf("period%0d", i), per, exp_per[i]);
            check($sformatf("curdiv%0d", i), divs[i], exp_per[i]);
            if (highs[i] != PLS_HI) bad_hi++;
        end
        check("bad_high_times", bad_hi, 0);
        check("done_time", done_at, 1 + sum);
        check("left_at_done", left_at_done, exp_left);
        check("busy_at_done", busy_at_done, 0);
        check("dir_at_done", bus.Dir, dir);
    endtask

    task automatic do_reject(input int sd, input int md);
        int npls;
        issue_start(5, sd, md, 10, 1'b1);
        check("rej_err", bus.Err, 1);
        check("rej_busy", bus.Busy, 0);
        npls = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.Pls_Out || bus.Busy || bus.Done) npls++;
        end
        check("rej_activity", npls, 0);
    endtask

    initial begin
        int nr, cnt, done_off, n_start, md, sd, acc, total, stop_at;
        bit prev;
        bus.Start = 0; bus.Stop = 0; bus.Abort = 0; bus.DirIn = 0;
        bus.TotalPls = '0; bus.StartDiv = '0; bus.MinDiv = '0; bus.AccStep = '0;
        repeat (3) @(negedge clk);
        check("rst_pls", bus.Pls_Out, 0);
        check("rst_busy", bus.Busy, 0);
        check("rst_done", bus.Done, 0);
        check("rst_err", bus.Err, 0);
        check("rst_dir", bus.Dir, 0);
        check("rst_left", bus.PlsLeft, 0);
        check("rst_curdiv", bus.CurDiv, 0);
        ng_rst = 1'b1;
        repeat (2) @(negedge clk);

        do_move(10, 100, 60, 10, 1'b0, 0, 0);
        do_move(10, 100, 60, 10, 1'b1, 3, 0);
        do_move(3, 100, 60, 10, 1'b0, 0, 0);

        // Abort three clocks into pulse 2, while the pulse is still high.
        issue_start(10, 100, 60, 10, 1'b1);
        nr = 0; prev = 0;
        for (int t = 0; t < 400 && nr < 2; t++) begin
            @(negedge clk);
            if (bus.Pls_Out && !prev) nr++;
            prev = bus.Pls_Out;
        end
        check("abort_reach_p2", nr, 2);
        repeat (2) @(negedge clk);
        check("abort_pre_pls", bus.Pls_Out, 1);
        bus.Abort = 1'b1;
        @(negedge clk);
        bus.Abort = 1'b0;
        check("abort_pls", bus.Pls_Out, 0);
        check("abort_busy", bus.Busy, 0);
        check("abort_left", bus.PlsLeft, 8);
        cnt = 0;
        repeat (300) begin
            @(negedge clk);
            if (bus.Done || bus.Pls_Out) cnt++;
        end
        check("abort_quiet", cnt, 0);

        do_reject(100, 10);
        do_reject(50, 60);

        issue_start(0, 100, 60, 10, 1'b1);
        n_start = cyc;
        check("zero_busy", bus.Busy, 0);
        check("zero_err", bus.Err, 0);
        done_off = -1; cnt = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (bus.Done && done_off < 0) done_off = cyc - n_start;
            if (bus.Pls_Out || bus.Busy) cnt++;
        end
        check("zero_done_time", done_off, 1);
        check("zero_activity", cnt, 0);

        do_move(5, 100, 60, 10, 1'b1, 0, 2);
        do_move(4, 100, 60, 16'hFFFF, 1'b0, 0, 0);

        // Reset pulled low while cruising must clear every output without waiting for a clock edge.
        issue_start(10, 100, 60, 10, 1'b1);
        nr = 0; prev = 0;
        for (int t = 0; t < 800 && nr < 6; t++) begin
            @(negedge clk);
            if (bus.Pls_Out && !prev) nr++;
            prev = bus.Pls_Out;
        end
        check("rst_reach_cruise", nr, 6);
        repeat (2) @(negedge clk);
        check("rst_pre_pls", bus.Pls_Out, 1);
        #2 ng_rst = 1'b0;
        #1;
        check("arst_pls", bus.Pls_Out, 0);
        check("arst_busy", bus.Busy, 0);
        check("arst_dir", bus.Dir, 0);
        check("arst_left", bus.PlsLeft, 0);
        check("arst_curdiv", bus.CurDiv, 0);
        check("arst_done_err", {bus.Done, bus.Err}, 0);
        @(negedge clk);
        ng_rst = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 12; k++) begin
            md = 16 + int'($urandom_range(0, 29));
            sd = md + int'($urandom_range(0, 49));
            acc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 14));
            total = 1 + int'($urandom_range(0, 11));
            stop_at = ($urandom_range(0, 2) == 0) ? 1 + int'($urandom_range(0, total - 1)) : 0;
            do_move(total, sd, md, acc, 1'($urandom_range(0, 1)), stop_at, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
